// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and default width shared by the ALU files
package alu_pkg;
  localparam int WIDTH = 8;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;
endpackage

// File: rtl/alu_comb.sv
// alu_comb: combinational evaluator for the single-cycle opcodes
module alu_comb
  import alu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [2:0]   op_i,
  output logic [W-1:0] y_o,
  output logic         c_o
);
  logic [W:0] sum;
  logic [W:0] dif;
  assign sum = {1'b0, a_i} + {1'b0, b_i};
  assign dif = {1'b0, a_i} - {1'b0, b_i};
  always_comb begin
    y_o = '0;
    c_o = 1'b0;
    case (op_i)
      OP_ADD: {c_o, y_o} = sum;
      OP_SUB: {c_o, y_o} = dif;
      OP_AND: y_o = a_i & b_i;
      OP_OR:  y_o = a_i | b_i;
      OP_XOR: y_o = a_i ^ b_i;
      OP_SHL: {c_o, y_o} = {a_i, 1'b0};
      OP_SHR: {y_o, c_o} = {1'b0, a_i};
      default: ;
    endcase
  end
endmodule

// File: rtl/alu_unit.sv
// alu_unit: multi-cycle ALU with single-cycle ops and an 8-iteration shift-add multiply
module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [0:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d, mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d, prod_nx;
  logic [WIDTH-1:0]   result_q, result_d, result_hi_q, result_hi_d;
  logic               carry_q, carry_d, zero_q, zero_d, done_q, done_d;
  logic [WIDTH-1:0]   cy;
  logic               cc;
  logic [WIDTH:0]     psum;
  logic [2*WIDTH:0]   pcat;
  alu_comb #(.W(WIDTH)) u_comb (
    .a_i (a_in),
    .b_i (b_in),
    .op_i(op),
    .y_o (cy),
    .c_o (cc)
  );
  // The 9-bit partial sum keeps the add carry so it shifts into the product top bit
  assign psum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  assign pcat    = {psum, prod_q[WIDTH-1:0]};
  assign prod_nx = pcat[2*WIDTH:1];
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    done_d      = 1'b0;
    if (state_q == S_IDLE && start) begin
      if (op == OP_MUL) begin
        mcand_d  = a_in;
        mplier_d = b_in;
        prod_d   = '0;
        cnt_d    = '0;
        state_d  = S_MUL;
      end else begin
        result_d    = cy;
        result_hi_d = '0;
        carry_d     = cc;
        zero_d      = (cy == '0);
        done_d      = 1'b1;
      end
    end else if (state_q == S_MUL) begin
      prod_d   = prod_nx;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        result_d    = prod_nx[WIDTH-1:0];
        result_hi_d = prod_nx[2*WIDTH-1:WIDTH];
        carry_d     = |prod_nx[2*WIDTH-1:WIDTH];
        zero_d      = (prod_nx[WIDTH-1:0] == '0);
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      done_q      <= done_d;
    end
  end
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign busy      = (state_q == S_MUL);
  assign done      = done_q;
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: vector table, directed corner sequences and random ops against an arithmetic model
module tb_alu_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [7:0] a_in, b_in;
  logic [7:0] result, result_hi;
  logic       carry, zero, busy, done;
  int checks = 0;
  int errors = 0;
  alu_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a_in     (a_in),
    .b_in     (b_in),
    .result   (result),
    .result_hi(result_hi),
    .carry    (carry),
    .zero     (zero),
    .busy     (busy),
    .done     (done)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b, res;
    logic       c, z;
  } vec_t;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    start = 1'b1; op = o; a_in = a; b_in = b;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    if (!done) chk("done_timeout", 16'(done), 16'd1);
  endtask
  task automatic model(input logic [2:0] o, input int a, input int b,
                       output int r, output int hi, output int c);
    int s;
    hi = 0; c = 0;
    case (o)
      3'd0: begin s = a + b; r = s % 256; c = int'(s > 255); end
      3'd1: begin r = (a - b + 256) % 256; c = int'(a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = (a * 2) % 256; c = int'(a >= 128); end
      3'd6: begin r = a / 2; c = a % 2; end
      default: begin s = a * b; r = s % 256; hi = s / 256; c = int'(hi != 0); end
    endcase
  endtask
  task automatic run_check(input string nm, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    int lat, r, hi, c;
    model(o, int'(a), int'(b), r, hi, c);
    issue(o, a, b);
    wait_done(lat);
    chk({nm, "_lat"}, 16'(lat), (o == 3'd7) ? 16'd9 : 16'd1);
    chk({nm, "_res"}, 16'(result), 16'(r));
    chk({nm, "_hi"}, 16'(result_hi), 16'(hi));
    chk({nm, "_c"}, 16'(carry), 16'(c));
    chk({nm, "_z"}, 16'(zero), 16'(r == 0));
  endtask
  vec_t vt[8];
  initial begin
    int lat, dones;
    logic [7:0] sr;
    vt[0] = '{3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0};
    vt[1] = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    vt[2] = '{3'd1, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vt[3] = '{3'd1, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1};
    vt[4] = '{3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
    vt[5] = '{3'd3, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0};
    vt[6] = '{3'd5, 8'h40, 8'h00, 8'h80, 1'b0, 1'b0};
    vt[7] = '{3'd6, 8'h02, 8'h00, 8'h01, 1'b0, 1'b0};
    reset = 1'b1; start = 1'b0; op = '0; a_in = '0; b_in = '0;
    for (int i = 0; i < 4; i++) begin
      start = 1'b1; op = 3'($urandom); a_in = 8'($urandom); b_in = 8'($urandom);
      tick();
    end
    chk("rst_outs", {result, result_hi}, 16'h0);
    chk("rst_flags", {12'h0, carry, zero, busy, done}, 16'h0);
    start = 1'b0;
    reset = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b);
      chk($sformatf("vec%0d_done", i), 16'(done), 16'd1);
      chk($sformatf("vec%0d_res", i), 16'(result), 16'(vt[i].res));
      chk($sformatf("vec%0d_cz", i), {14'h0, carry, zero}, {14'h0, vt[i].c, vt[i].z});
      chk($sformatf("vec%0d_hi", i), 16'(result_hi), 16'h0);
    end
    tick();
    chk("done_drop", 16'(done), 16'd0);
    repeat (3) tick();
    chk("hold_res", {result, 6'h0, carry, zero}, {8'h01, 8'h00});
    start = 1'b1; op = 3'd4; a_in = 8'hAA; b_in = 8'hFF;
    tick();
    chk("b2b_xor", {7'h0, done, result}, {8'h01, 8'h55});
    op = 3'd5; a_in = 8'h81;
    tick();
    chk("b2b_shl", {6'h0, done, carry, result}, {8'h03, 8'h02});
    op = 3'd6; a_in = 8'h01;
    tick();
    chk("b2b_shr", {5'h0, done, carry, zero, result}, {8'h07, 8'h00});
    start = 1'b0;
    tick();
    chk("b2b_end", 16'(done), 16'd0);
    issue(3'd7, 8'd13, 8'd11);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("mul_busy%0d", i), {14'h0, busy, done}, 16'h2);
      tick();
    end
    chk("mul_fin", {6'h0, busy, done, result}, {8'h01, 8'h8F});
    chk("mul_fin_hc", {7'h0, carry, result_hi}, 16'h0);
    run_check("mul_ff", 3'd7, 8'hFF, 8'hFF);
    chk("mul_ff_lit", {result_hi, result}, 16'hFE01);
    issue(3'd7, 8'd13, 8'd11);
    dones = 0;
    sr = 8'h00;
    for (int i = 0; i < 14; i++) begin
      start = (i >= 1 && i <= 5);
      op = 3'd0; a_in = 8'($urandom); b_in = 8'($urandom);
      if (done) begin dones++; sr = result; end
      tick();
    end
    start = 1'b0;
    chk("busy_ign_cnt", 16'(dones), 16'd1);
    chk("busy_ign_res", 16'(sr), 16'h8F);
    issue(3'd7, 8'd200, 8'd3);
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    chk("midrst_outs", {result, result_hi}, 16'h0);
    chk("midrst_flags", {12'h0, carry, zero, busy, done}, 16'h0);
    tick();
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) dones++;
      tick();
    end
    chk("midrst_nodone", 16'(dones), 16'd0);
    run_check("post_add", 3'd0, 8'd2, 8'd3);
    chk("post_add_lit", 16'(result), 16'h05);
    for (int i = 0; i < 40; i++)
      run_check($sformatf("rnd%0d", i), 3'($urandom), 8'($urandom), 8'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
